// File: rtl/uart_rx_param_if.sv
// Read/status port between the UART receiver and the core's memory-mapped read logic.
interface uart_rx_param_if #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                 rd_en;
  logic                 err_clr;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_valid;
  logic [CNT_W-1:0]     fifo_count;
  logic                 parity_error;
  logic                 framing_error;
  logic                 overrun;

  modport master (
    output rd_en, err_clr,
    input  rd_data, rd_valid, fifo_count, parity_error, framing_error, overrun
  );

  modport slave (
    input  rd_en, err_clr,
    output rd_data, rd_valid, fifo_count, parity_error, framing_error, overrun
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, frame FSM, one-stage result register,
// first-word-fall-through receive FIFO and sticky error flags.
module uart_rx_param #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  output logic            busy,
  uart_rx_param_if.slave  bus
);
  localparam int unsigned TICK_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  logic rx_meta, rx_s, rx_prev;

  state_e               state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 done_c, frame_ferr_c;

  logic                 res_valid, res_perr, res_ferr;
  logic [DATA_BITS-1:0] res_word;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_d;
  logic [DATA_BITS-1:0] head_d;
  logic                 pop_c, push_c, full_c, good_c;
  logic                 perr_set_c, ferr_set_c, ovr_set_c;

  // Two-flop synchroniser plus one history flop for start-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // Frame FSM next-state and datapath.
  always_comb begin
    state_d      = state_q;
    tick_d       = tick_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    perr_d       = perr_q;
    ferr_d       = ferr_q;
    done_c       = 1'b0;
    frame_ferr_c = ferr_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_prev && !rx_s) begin
          state_d = S_START;
          tick_d  = TICK_W'(CLKS_PER_BIT / 2 - 1);
        end
      end
      S_START: begin
        if (tick_q == '0) begin
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            tick_d  = TICK_W'(CLKS_PER_BIT - 1);
            bit_d   = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end else begin
          tick_d = tick_q - TICK_W'(1);
        end
      end
      S_DATA: begin
        if (tick_q == '0) begin
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          tick_d  = TICK_W'(CLKS_PER_BIT - 1);
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          tick_d = tick_q - TICK_W'(1);
        end
      end
      S_PARITY: begin
        if (tick_q == '0) begin
          perr_d  = (^shreg_q) ^ rx_s ^ 1'(PARITY_ODD);
          tick_d  = TICK_W'(CLKS_PER_BIT - 1);
          bit_d   = '0;
          state_d = S_STOP;
        end else begin
          tick_d = tick_q - TICK_W'(1);
        end
      end
      S_STOP: begin
        if (tick_q == '0) begin
          tick_d       = TICK_W'(CLKS_PER_BIT - 1);
          ferr_d       = ferr_q | ~rx_s;
          frame_ferr_c = ferr_q | ~rx_s;
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            done_c  = 1'b1;
            state_d = S_IDLE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          tick_d = tick_q - TICK_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, busy and the completed-frame result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_word  <= '0;
      res_perr  <= 1'b0;
      res_ferr  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      busy      <= (state_q != S_IDLE);
      res_valid <= done_c;
      if (done_c) begin
        res_word <= shreg_q;
        res_perr <= perr_q;
        res_ferr <= frame_ferr_c;
      end
    end
  end

  // FIFO control; the head is precomputed so rd_data/rd_valid leave flops.
  always_comb begin
    pop_c      = bus.rd_en && (bus.fifo_count != '0);
    full_c     = (bus.fifo_count == CNT_W'(FIFO_DEPTH));
    good_c     = res_valid && !res_ferr;
    push_c     = good_c && (!full_c || pop_c);
    perr_set_c = good_c && res_perr;
    ferr_set_c = res_valid && res_ferr;
    ovr_set_c  = good_c && full_c && !pop_c;
    wr_ptr_d   = push_c ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop_c  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    unique case ({push_c, pop_c})
      2'b10:   count_d = bus.fifo_count + CNT_W'(1);
      2'b01:   count_d = bus.fifo_count - CNT_W'(1);
      default: count_d = bus.fifo_count;
    endcase
    if (count_d == '0)                            head_d = '0;
    else if (push_c && (rd_ptr_d == wr_ptr_q))    head_d = res_word;
    else                                          head_d = mem[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr_q] <= res_word;
  end

  // Pointers, count, read head and sticky flags (set beats clear).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      bus.fifo_count    <= '0;
      bus.rd_data       <= '0;
      bus.rd_valid      <= 1'b0;
      bus.parity_error  <= 1'b0;
      bus.framing_error <= 1'b0;
      bus.overrun       <= 1'b0;
    end else begin
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      bus.fifo_count    <= count_d;
      bus.rd_data       <= head_d;
      bus.rd_valid      <= (count_d != '0);
      bus.parity_error  <= perr_set_c | (bus.parity_error  & ~bus.err_clr);
      bus.framing_error <= ferr_set_c | (bus.framing_error & ~bus.err_clr);
      bus.overrun       <= ovr_set_c  | (bus.overrun       & ~bus.err_clr);
    end
  end
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed + randomized bench for uart_rx_param against a queue-based frame model.
module tb_uart_rx_param;
  localparam int CPB = 8, DB = 8, PE = 1, PO = 0, SB = 1, FD = 4;
  localparam int L = 3 + CPB / 2 + (DB + PE + SB) * CPB;

  logic clk = 1'b0, rst = 1'b0, rx = 1'b1, busy;
  int   cyc = 0;
  int   tests = 0, fails = 0;

  logic [7:0] exp_q[$];
  bit         m_perr, m_ferr, m_ovr;

  uart_rx_param_if #(.DATA_BITS(DB), .FIFO_DEPTH(FD)) bus ();

  uart_rx_param #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_EN(PE),
    .PARITY_ODD(PO), .STOP_BITS(SB), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_valid"}, 32'(bus.rd_valid), 32'(exp_q.size() != 0));
    chk({tag, "_count"}, 32'(bus.fifo_count), 32'(exp_q.size()));
    chk({tag, "_data"},  32'(bus.rd_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
    chk({tag, "_perr"},  32'(bus.parity_error), 32'(m_perr));
    chk({tag, "_ferr"},  32'(bus.framing_error), 32'(m_ferr));
    chk({tag, "_ovr"},   32'(bus.overrun), 32'(m_ovr));
    chk({tag, "_busy"},  32'(busy), 32'h0);
  endtask

  // Drive one frame starting at the current negedge; lat_kind 1 = watch rd_valid, 2 = framing_error.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input int lat_kind, input bit pop_at, input bit clr_at);
    bit   fb[$];
    int   e0, c;
    bit   popped, full;
    logic [7:0] tmp;
    fb.push_back(1'b0);
    for (int i = 0; i < DB; i++) fb.push_back(d[i]);
    if (PE != 0) fb.push_back((^d) ^ 1'(PO) ^ bad_par);
    for (int i = 0; i < SB; i++) fb.push_back(!bad_stop);
    e0 = cyc + 1;
    foreach (fb[i]) begin
      rx = fb[i];
      repeat (CPB) begin
        @(negedge clk);
        c = cyc - e0;
        if (lat_kind != 0 && c == 2) chk("busy_pre", 32'(busy), 32'h0);
        if (lat_kind != 0 && c == 3) chk("busy_rise", 32'(busy), 32'h1);
        if (c == L - 1) begin
          if (lat_kind == 1) chk("lat_valid_pre", 32'(bus.rd_valid), 32'h0);
          if (lat_kind == 2) chk("lat_ferr_pre", 32'(bus.framing_error), 32'h0);
          if (lat_kind != 0) chk("busy_hold", 32'(busy), 32'h1);
          if (pop_at) begin
            chk("pop_at_data", 32'(bus.rd_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
            bus.rd_en = 1'b1;
          end
          if (clr_at) bus.err_clr = 1'b1;
        end
        if (c == L) begin
          bus.rd_en   = 1'b0;
          bus.err_clr = 1'b0;
          if (lat_kind == 1) chk("lat_valid", 32'(bus.rd_valid), 32'h1);
          if (lat_kind == 2) chk("lat_ferr", 32'(bus.framing_error), 32'h1);
          if (lat_kind != 0) chk("busy_fall", 32'(busy), 32'h0);
        end
      end
    end
    rx = 1'b1;
    popped = pop_at && (exp_q.size() != 0);
    full   = (exp_q.size() == FD);
    if (popped) tmp = exp_q.pop_front();
    if (clr_at) begin m_perr = 0; m_ferr = 0; m_ovr = 0; end
    if (bad_stop) m_ferr = 1;
    else begin
      if (bad_par) m_perr = 1;
      if (!full || popped) exp_q.push_back(d);
      else m_ovr = 1;
    end
  endtask

  task automatic pop_one(input string tag);
    logic [7:0] tmp;
    chk({tag, "_pop_data"}, 32'(bus.rd_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    if (exp_q.size() != 0) tmp = exp_q.pop_front();
  endtask

  task automatic clear_flags();
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    m_perr = 0; m_ferr = 0; m_ovr = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bit         saw;
    logic [7:0] d;
    bus.rd_en = 1'b0;
    bus.err_clr = 1'b0;
    m_perr = 0; m_ferr = 0; m_ovr = 0;
    idle(3);
    check_all("reset");
    rst = 1'b1;
    idle(5);

    // Single frame with exact latency, then pop.
    send_frame(8'hEA, 0, 0, 1, 0, 0);
    check_all("single");
    pop_one("single");
    check_all("single_popped");

    // Back-to-back frames, no gap.
    send_frame(8'hEA, 0, 0, 0, 0, 0);
    send_frame(8'h50, 0, 0, 0, 0, 0);
    check_all("b2b");
    pop_one("b2b0");
    pop_one("b2b1");
    check_all("b2b_empty");

    // Parity error, clear, then set-beats-clear.
    send_frame(8'h50, 1, 0, 0, 0, 0);
    check_all("par");
    clear_flags();
    check_all("par_clr");
    send_frame(8'h50, 1, 0, 0, 0, 1);
    check_all("par_setwins");
    pop_one("par0");
    pop_one("par1");
    clear_flags();
    check_all("par_done");

    // Framing error discards the word.
    idle(4);
    send_frame(8'hEA, 0, 1, 2, 0, 0);
    check_all("frm");
    clear_flags();
    idle(CPB);
    check_all("frm_clr");

    // Short low glitch is a false start.
    saw = 0;
    rx = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 1) rx = 1'b1;
      if (busy) saw = 1;
    end
    chk("glitch_busy_seen", 32'(saw), 32'h1);
    check_all("glitch");

    // Overrun on the fifth frame with no reads.
    for (int i = 0; i < FD + 1; i++) begin
      d = 8'($urandom);
      send_frame(d, 0, 0, 0, 0, 0);
    end
    check_all("ovr");
    for (int i = 0; i < FD; i++) pop_one("ovr_drain");
    clear_flags();
    check_all("ovr_clr");

    // Same, but popping at the fifth completion avoids overrun.
    for (int i = 0; i < FD + 1; i++) begin
      d = 8'($urandom);
      send_frame(d, 0, 0, 0, i == FD, 0);
    end
    check_all("noovr");
    for (int i = 0; i < FD; i++) pop_one("noovr_drain");
    check_all("noovr_empty");

    // Randomized frames with random parity faults and pops.
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      send_frame(d, ($urandom_range(0, 3) == 0), 0, 0, 1'($urandom_range(0, 1)), 0);
      check_all("rand");
    end
    while (exp_q.size() != 0) pop_one("rand_drain");
    clear_flags();
    check_all("rand_done");

    // Reset in the middle of DATA, then a clean frame.
    rx = 1'b0;
    idle(CPB * 3);
    rst = 1'b0;
    rx = 1'b1;
    exp_q.delete();
    m_perr = 0; m_ferr = 0; m_ovr = 0;
    @(negedge clk);
    check_all("midrst");
    rst = 1'b1;
    idle(4);
    d = 8'($urandom);
    send_frame(d, 0, 0, 1, 0, 0);
    check_all("post_rst");
    pop_one("post_rst");
    check_all("post_rst_empty");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver with programmable data width, optional even/odd parity, one or two stop bits, and a first-word-fall-through receive FIFO with sticky error reporting. It replaces the fixed 8-bit receive path of the full-duplex UART and sits between the `rx` pin and the core's memory-mapped UART read port. Frames are buffered so that the core can fall behind by up to `FIFO_DEPTH` words without losing data.

## Interface
- CLKS_PER_BIT, 8, clock cycles per UART bit; must be even and ≥ 4
- DATA_BITS, 8, data bits per frame (5–9), LSB first
- PARITY_EN, 1, 1 = a parity bit follows the data bits
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored if PARITY_EN=0)
- STOP_BITS, 1, number of stop bits (1 or 2)
- FIFO_DEPTH, 4, number of receive FIFO entries (power of 2, ≥ 2)

- clk  in  1  system clock
- rst  in  1  reset; one clock, asynchronous, active-low
- rx  in  1  serial input, asynchronous, idle high
- rd_en  in  1  pop request for the FIFO head
- err_clr  in  1  one-cycle pulse that clears all sticky error flags
- rd_data  out  DATA_BITS  FIFO head (first-word-fall-through); 0 when empty
- rd_valid  out  1  FIFO not empty
- fifo_count  out  $clog2(FIFO_DEPTH+1)  number of words held
- parity_error  out  1  sticky flag: a parity mismatch was received
- framing_error  out  1  sticky flag: a stop bit was sampled as 0
- overrun  out  1  sticky flag: a good word arrived while the FIFO was full
- busy  out  1  FSM is not in IDLE

## Operation
- Input synchroniser: two flops on `rx`, reset to 1. All FSM decisions use the synchronised `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP. The bit counter counts down from CLKS_PER_BIT-1; a "sample" occurs when it reaches 0.
- IDLE: a falling edge of `rx_s` (previous 1, current 0) moves the FSM to START and loads the counter with CLKS_PER_BIT/2-1.
- START: at the sample, if `rx_s`=1 it is a false start and the FSM returns to IDLE with no flags set. Otherwise the FSM moves to DATA and the counter reloads to CLKS_PER_BIT-1.
- DATA: DATA_BITS samples are shifted in LSB first. The FSM then goes to PARITY if PARITY_EN=1, else to STOP.
- PARITY: there is one sample. There is a mismatch when XOR(data) ^ rx_s ^ PARITY_ODD ≠ 0.
- STOP: STOP_BITS samples. Any stop sample of 0 marks a framing error for that frame.
- Frame completion, at the last stop sample; the FSM returns to IDLE in the same cycle:
  - On a framing error, `framing_error` is set and the word is discarded, regardless of parity.
  - Otherwise, on a parity mismatch, `parity_error` is set and the word is still pushed.
  - The push goes ahead if the FIFO is not full, or if `rd_en` pops in the same cycle. If the FIFO is full with no pop, the word is dropped and `overrun` is set.
- FIFO: circular buffer with read/write pointers and a count.
  - `rd_en` while empty is ignored.
  - A simultaneous push and pop leaves the count unchanged, including when the FIFO is full.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags: each flag is cleared by `err_clr`. If a set and a clear happen in the same cycle, the set wins.
- Line held low (break): START and DATA complete, the stop sample reads 0, `framing_error` is set and the word is discarded. A new frame requires `rx_s` to return high and then fall again.

## Timing
- Reset values:
  - All outputs 0: `rd_data`=0, `rd_valid`=0, `fifo_count`=0, all flags 0, `busy`=0.
  - FSM in IDLE, synchroniser flops at 1.
- Reset asserted mid-frame aborts the frame immediately. No partial word is pushed and the FIFO is emptied.
- Let E0 be the first rising edge of `clk` at which raw `rx`=0. Then:
  - `busy` rises 3 cycles after E0.
  - `rd_valid` (or the relevant error flag) rises L = 3 + CLKS_PER_BIT/2 + (DATA_BITS+PARITY_EN+STOP_BITS)·CLKS_PER_BIT cycles after E0.
  - With the defaults, L = 3 + 4 + 10·8 = 87.
- `busy` falls in the same cycle the result appears.
- Back-to-back frames with no idle gap are received without loss: the FSM is in IDLE half a bit before the next start edge.
- `rd_data` and `rd_valid` change on the clock edge after a push into an empty FIFO or after a pop; there is no registered read latency beyond that.
- `fifo_count` updates on the same edge as the pointers.

## Test plan
- Defaults, with the frame for 8'hEA sent with correct even parity → `rd_valid` high at E0+87, `rd_data`=8'hEA, all flags 0. After one `rd_en` pulse → `rd_valid`=0, `fifo_count`=0.
- Back-to-back frames 8'hEA then 8'h50, no gap, no reads → `fifo_count`=2, with 8'hEA popped first, then 8'h50, no flags.
- Frame 8'h50 with an inverted parity bit → word 8'h50 pushed, `parity_error`=1. An `err_clr` pulse clears it, except in a cycle where a new error is also being set, in which case it stays 1.
- Frame 8'hEA with the stop bit forced to 0 → `framing_error`=1, `fifo_count` unchanged.
- A low glitch on `rx` of 2 cycles → `busy` pulses and returns to 0, nothing is pushed, no flags are set.
- FIFO_DEPTH+1 = 5 good frames with no reads → `fifo_count`=4, `overrun`=1, and the FIFO holds the first 4 words. Repeat with `rd_en` asserted at the 5th completion → no overrun.
- Reset (`rst`=0) asserted during DATA → all outputs 0. The next complete frame is received correctly.
